// File: rtl/bus_write_checker_pkg.sv
// bus_write_checker_pkg: shared types and constants for the bus store checker.
//   - checker state encoding
//   - default bus/counter widths
//   - entry_w(): width of one packed expectation-table entry
// Optional feature macro: BUS_WRITE_CHECKER_TIMESTAMP_EN (adds a time field per entry).
package bus_write_checker_pkg;

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_armed = 2'd1,
        st_pass  = 2'd2,
        st_fail  = 2'd3
    } state_t;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned DEF_CNT_W  = 16;

`ifdef BUS_WRITE_CHECKER_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Packed entry layout (MSB..LSB): [time,] addr, data
    function automatic int unsigned entry_w(int unsigned aw, int unsigned dw, int unsigned cw);
        return aw + dw + (TS_EN ? cw : 0);
    endfunction

endpackage

// File: rtl/bus_write_checker_if.sv
// bus_write_checker_if: snooped cpu6502-style bus.
//   addr   - CPU address
//   data   - CPU write data (odata)
//   rw     - 1 = read, 0 = write
//   strobe - phase strobe (clk2); a store is qualified on its rising edge
// Modports: master drives the bus, slave (the checker) observes it.
interface bus_write_checker_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
    logic              strobe;

    modport master (output addr, output data, output rw, output strobe);
    modport slave  (input addr, input data, input rw, input strobe);
endinterface

// File: rtl/bwc_table.sv
// bwc_table: DEPTH-entry expectation register file.
//   clk    - system clock
//   we     - synchronous write enable
//   widx   - write index
//   wentry - packed entry to write
//   ridx   - combinational read index
//   rentry - packed entry at ridx
// Contents have no reset so a loaded table survives a checker reset.
module bwc_table #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [WIDTH-1:0]         wentry,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output logic [WIDTH-1:0]         rentry
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wentry;
        end
    end

    assign rentry = mem[ridx];
endmodule

// File: rtl/bus_write_checker.sv
// bus_write_checker: compares each CPU store, in order, against a loaded expectation table.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   arm, n_expected      - start/restart checking with n_expected entries (clamped to DEPTH)
//   tbl_we/idx/addr/data/time - table load port, honoured only in IDLE
//   bus                  - snooped bus (slave modport)
//   done, pass, fail     - status
//   match_count          - stores matched so far
//   fail_idx/addr/data   - details of the first failure
//   cycle_count          - clocks since arm (saturating)
// Optional feature macro: BUS_WRITE_CHECKER_TIMESTAMP_EN (a match also needs cycle_count == time).
module bus_write_checker
    import bus_write_checker_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic [$clog2(DEPTH):0]   n_expected,
    input  logic                     tbl_we,
    input  logic [$clog2(DEPTH)-1:0] tbl_idx,
    input  logic [ADDR_W-1:0]        tbl_addr,
    input  logic [DATA_W-1:0]        tbl_data,
    input  logic [CNT_W-1:0]         tbl_time,
    bus_write_checker_if.slave       bus,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic [$clog2(DEPTH):0]   match_count,
    output logic [$clog2(DEPTH):0]   fail_idx,
    output logic [ADDR_W-1:0]        fail_addr,
    output logic [DATA_W-1:0]        fail_data,
    output logic [CNT_W-1:0]         cycle_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;
    localparam int unsigned EW    = entry_w(ADDR_W, DATA_W, CNT_W);

    state_t            state_q, state_d;
    logic              strobe_q, sticky_q, sticky_d;
    logic [CW-1:0]     n_q, n_d, ptr_q, ptr_d, match_q, match_d, fidx_q, fidx_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;

    logic [EW-1:0]     wentry, rentry;
    logic [CW-1:0]     n_clamped, ptr_next;
    logic              store_ev, time_ok, entry_ok;

    bwc_table #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_table (
        .clk    (clk),
        .we     (tbl_we & (state_q == st_idle) & ~reset),
        .widx   (tbl_idx),
        .wentry (wentry),
        .ridx   (ptr_q[PTR_W-1:0]),
        .rentry (rentry)
    );

`ifdef BUS_WRITE_CHECKER_TIMESTAMP_EN
    assign wentry  = {tbl_time, tbl_addr, tbl_data};
    assign time_ok = (rentry[EW-1 -: CNT_W] == cycle_q);
`else
    logic unused_time;
    assign unused_time = ^tbl_time;
    assign wentry      = {tbl_addr, tbl_data};
    assign time_ok     = 1'b1;
`endif

    // One event per strobe rising edge; reads never count
    assign store_ev  = bus.strobe & ~strobe_q & ~bus.rw;
    assign entry_ok  = (bus.addr == rentry[DATA_W +: ADDR_W]) &&
                       (bus.data == rentry[DATA_W-1:0]) && time_ok;
    assign n_clamped = (n_expected > CW'(DEPTH)) ? CW'(DEPTH) : n_expected;
    assign ptr_next  = ptr_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        ptr_d    = ptr_q;
        match_d  = match_q;
        sticky_d = sticky_q;
        fidx_d   = fidx_q;
        faddr_d  = faddr_q;
        fdata_d  = fdata_q;
        cycle_d  = cycle_q;

        if ((state_q == st_armed || state_q == st_pass) && cycle_q != '1) begin
            cycle_d = cycle_q + 1'b1;
        end

        // arm takes priority over a coincident store
        if (arm) begin
            state_d  = (n_clamped == '0) ? st_pass : st_armed;
            n_d      = n_clamped;
            ptr_d    = '0;
            match_d  = '0;
            sticky_d = 1'b0;
            fidx_d   = '0;
            faddr_d  = '0;
            fdata_d  = '0;
            cycle_d  = '0;
        end else if (store_ev) begin
            case (state_q)
                st_armed: begin
                    if (entry_ok) begin
                        match_d = match_q + 1'b1;
                    end else if (!sticky_q) begin
                        fidx_d  = ptr_q;
                        faddr_d = bus.addr;
                        fdata_d = bus.data;
                    end
                    if (!entry_ok && STOP_ON_FAIL) begin
                        state_d = st_fail;
                    end else begin
                        ptr_d = ptr_next;
                        if (!entry_ok) begin
                            sticky_d = 1'b1;
                        end
                        if (ptr_next == n_q) begin
                            state_d = (sticky_q || !entry_ok) ? st_fail : st_pass;
                        end
                    end
                end
                st_pass: begin
                    // Any store after the table is exhausted is unexpected
                    fidx_d  = n_q;
                    faddr_d = bus.addr;
                    fdata_d = bus.data;
                    state_d = st_fail;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= st_idle;
            strobe_q <= 1'b0;
            sticky_q <= 1'b0;
            n_q      <= '0;
            ptr_q    <= '0;
            match_q  <= '0;
            fidx_q   <= '0;
            faddr_q  <= '0;
            fdata_q  <= '0;
            cycle_q  <= '0;
        end else begin
            state_q  <= state_d;
            strobe_q <= bus.strobe;
            sticky_q <= sticky_d;
            n_q      <= n_d;
            ptr_q    <= ptr_d;
            match_q  <= match_d;
            fidx_q   <= fidx_d;
            faddr_q  <= faddr_d;
            fdata_q  <= fdata_d;
            cycle_q  <= cycle_d;
        end
    end

    assign done        = (state_q == st_pass) || (state_q == st_fail);
    assign pass        = (state_q == st_pass);
    assign fail        = (state_q == st_fail) || sticky_q;
    assign match_count = match_q;
    assign fail_idx    = fidx_q;
    assign fail_addr   = faddr_q;
    assign fail_data   = fdata_q;
    assign cycle_count = cycle_q;
endmodule
